pipe_seq_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/load_use_detect.sv | 24 ++
 rtl/pipe_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipeline sequencing controller: FSM state
// encodings (visible to the debug unit through o_state) and the default
// length of the post-HALT drain sequence.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        PAUSE  = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4
    } state_t;

    // Pipeline-enabled cycles spent in DRAIN before HALTED.
    localparam int DRAIN_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect
// Flags a load-use hazard: the instruction in EX is a load whose destination
// register is read by the instruction in ID. Register 0 never creates a
// hazard because it is hard-wired to zero.
// Ports:
//   ID_rs, ID_rt  in  source register names of the instruction in ID
//   EX_rt         in  destination register name of the load in EX
//   EX_memread    in  instruction in EX reads memory
//   hazard        out ID must wait one cycle for the load data
module load_use_detect #(
    parameter int RBITS = 5
) (
    input  logic [RBITS-1:0] ID_rs,
    input  logic [RBITS-1:0] ID_rt,
    input  logic [RBITS-1:0] EX_rt,
    input  logic             EX_memread,
    output logic             hazard
);

    assign hazard = EX_memread
                  && (EX_rt != '0)
                  && ((EX_rt == ID_rs) || (EX_rt == ID_rt));

endmodule

// File: rtl/pipe_seq_ctrl.sv
// pipe_seq_ctrl
// Pipeline sequencing controller for the 5-stage core. Generates the stall,
// flush and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB from the
// debug run/step/halt commands, load-use hazards, taken branches and the HALT
// instruction. After HALT is decoded the front end is frozen and the
// in-flight instructions are retired over DRAIN_CYCLES cycles.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_cmd_run/step/halt     debug command pulses (priority halt > step > run)
//   i_halt_id               HALT opcode decoded in ID
//   i_branch_taken          branch/jump resolved taken in ID
//   ID_rs, ID_rt, EX_rt,    operands for load-use detection
//   EX_memread
//   o_stall_pc..o_stall_mem hold PC / IF-ID / ID-EX / EX-MEM / MEM-WB
//   o_flush_if              load NOP into IF/ID
//   o_bubble_id             zero ID control signals before ID/EX
//   o_state, o_halted       FSM state and HALTED indication
//   o_cycles                saturating count of pipeline-advancing cycles
module pipe_seq_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NBITS        = 32,
    parameter int RBITS        = 5,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_run,
    input  logic             i_cmd_step,
    input  logic             i_cmd_halt,
    input  logic             i_halt_id,
    input  logic             i_branch_taken,
    input  logic [RBITS-1:0] ID_rs,
    input  logic [RBITS-1:0] ID_rt,
    input  logic [RBITS-1:0] EX_rt,
    input  logic             EX_memread,
    output logic             o_stall_pc,
    output logic             o_stall_if,
    output logic             o_stall_id,
    output logic             o_stall_ex,
    output logic             o_stall_mem,
    output logic             o_flush_if,
    output logic             o_bubble_id,
    output logic [2:0]       o_state,
    output logic             o_halted,
    output logic [NBITS-1:0] o_cycles
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

    state_t           state, state_nxt;
    logic [DCW-1:0]   drain_cnt;
    logic [NBITS-1:0] cycles;
    logic             hazard_raw;
    logic             executing;
    logic             hazard;
    logic             halt_seen;
    logic             advancing;

    load_use_detect #(.RBITS(RBITS)) u_load_use_detect (
        .ID_rs      (ID_rs),
        .ID_rt      (ID_rt),
        .EX_rt      (EX_rt),
        .EX_memread (EX_memread),
        .hazard     (hazard_raw)
    );

    // Hazards and HALT decode only matter while instructions are flowing;
    // a HALT held behind a load-use stall is re-decoded next cycle.
    assign executing = (state == RUN) || (state == STEP);
    assign hazard    = executing && hazard_raw;
    assign halt_seen = executing && i_halt_id && !hazard_raw;
    assign advancing = executing || (state == DRAIN);

    // NOTE: every signal driven here gets a default first so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        o_stall_pc  = 1'b1;
        o_stall_if  = 1'b1;
        o_stall_id  = 1'b1;
        o_stall_ex  = 1'b1;
        o_stall_mem = 1'b1;
        o_flush_if  = 1'b0;
        o_bubble_id = 1'b0;

        unique case (state)
            PAUSE: begin
                if (i_cmd_halt)      state_nxt = PAUSE;
                else if (i_cmd_step) state_nxt = STEP;
                else if (i_cmd_run)  state_nxt = RUN;
            end
            RUN, STEP: begin
                o_stall_id  = 1'b0;
                o_stall_ex  = 1'b0;
                o_stall_mem = 1'b0;
                if (hazard) begin
                    // Hold the consumer in ID and send a bubble down; the
                    // branch (if any) is resolved again next cycle.
                    o_stall_pc  = 1'b1;
                    o_stall_if  = 1'b1;
                    o_bubble_id = 1'b1;
                end else begin
                    o_stall_pc = 1'b0;
                    o_stall_if = 1'b0;
                    o_flush_if = i_branch_taken;
                end

                if (halt_seen)                        state_nxt = DRAIN;
                else if (state == STEP || i_cmd_halt) state_nxt = PAUSE;
            end
            DRAIN: begin
                // Front end frozen on NOPs while the back end retires.
                o_stall_pc  = 1'b1;
                o_stall_if  = 1'b0;
                o_stall_id  = 1'b0;
                o_stall_ex  = 1'b0;
                o_stall_mem = 1'b0;
                o_flush_if  = 1'b1;
                o_bubble_id = 1'b1;
                if (drain_cnt == '0) state_nxt = HALTED;
            end
            HALTED: state_nxt = HALTED;
            default: state_nxt = PAUSE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= PAUSE;
            drain_cnt <= '0;
            cycles    <= '0;
        end else begin
            state <= state_nxt;

            if (state != DRAIN && state_nxt == DRAIN)
                drain_cnt <= DRAIN_LOAD;
            else if (state == DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - 1'b1;

            if (advancing && cycles != '1)
                cycles <= cycles + 1'b1;
        end
    end

    assign o_state  = state;
    assign o_halted = (state == HALTED);
    assign o_cycles = cycles;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// tb_pipe_seq_ctrl
// Directed bench for pipe_seq_ctrl. The cycle counter is built narrow (4 bits)
// so the HALT sequence also drives it into saturation.
module tb_pipe_seq_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int NB = 4;
    localparam int RB = 5;

    // Control bundle order: {stall_pc, stall_if, stall_id, stall_ex,
    // stall_mem, flush_if, bubble_id}.
    localparam logic [6:0] FROZEN = 7'b1111100;
    localparam logic [6:0] OPEN   = 7'b0000000;
    localparam logic [6:0] HAZ    = 7'b1100001;
    localparam logic [6:0] BRANCH = 7'b0000010;
    localparam logic [6:0] DRAINO = 7'b1000011;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_cmd_run, i_cmd_step, i_cmd_halt;
    logic          i_halt_id, i_branch_taken;
    logic [RB-1:0] ID_rs, ID_rt, EX_rt;
    logic          EX_memread;
    logic          o_stall_pc, o_stall_if, o_stall_id, o_stall_ex, o_stall_mem;
    logic          o_flush_if, o_bubble_id;
    logic [2:0]    o_state;
    logic          o_halted;
    logic [NB-1:0] o_cycles;

    always #5 i_clk = ~i_clk;

    pipe_seq_ctrl #(.NBITS(NB), .RBITS(RB), .DRAIN_CYCLES(4)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_cmd_run      (i_cmd_run),
        .i_cmd_step     (i_cmd_step),
        .i_cmd_halt     (i_cmd_halt),
        .i_halt_id      (i_halt_id),
        .i_branch_taken (i_branch_taken),
        .ID_rs          (ID_rs),
        .ID_rt          (ID_rt),
        .EX_rt          (EX_rt),
        .EX_memread     (EX_memread),
        .o_stall_pc     (o_stall_pc),
        .o_stall_if     (o_stall_if),
        .o_stall_id     (o_stall_id),
        .o_stall_ex     (o_stall_ex),
        .o_stall_mem    (o_stall_mem),
        .o_flush_if     (o_flush_if),
        .o_bubble_id    (o_bubble_id),
        .o_state        (o_state),
        .o_halted       (o_halted),
        .o_cycles       (o_cycles)
    );

    typedef struct {
        logic          memread;
        logic [RB-1:0] ex_rt;
        logic [RB-1:0] id_rs;
        logic [RB-1:0] id_rt;
        logic          branch;
        logic [6:0]    exp_ctrl;
    } vec_t;

    vec_t vecs[8];
    int   n_vec = 0;
    int   n_bad = 0;

    // {state, halted, control bundle}
    function automatic logic [10:0] obs();
        return {o_state, o_halted, o_stall_pc, o_stall_if, o_stall_id,
                o_stall_ex, o_stall_mem, o_flush_if, o_bubble_id};
    endfunction

    function automatic logic [10:0] expect_of(input state_t s, input logic [6:0] ctrl);
        return {3'(s), (s == HALTED), ctrl};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(negedge i_clk);
    endtask

    task automatic clear_inputs();
        i_cmd_run      = 1'b0;
        i_cmd_step     = 1'b0;
        i_cmd_halt     = 1'b0;
        i_halt_id      = 1'b0;
        i_branch_taken = 1'b0;
        ID_rs          = '0;
        ID_rt          = '0;
        EX_rt          = '0;
        EX_memread     = 1'b0;
    endtask

    initial begin
        //          memread ex_rt id_rs id_rt branch expected
        vecs[0] = '{1'b1, 5'd8,  5'd8,  5'd0,  1'b0, HAZ};
        vecs[1] = '{1'b1, 5'd0,  5'd0,  5'd0,  1'b0, OPEN};
        vecs[2] = '{1'b1, 5'd8,  5'd3,  5'd8,  1'b1, HAZ};
        vecs[3] = '{1'b0, 5'd8,  5'd8,  5'd0,  1'b1, BRANCH};
        vecs[4] = '{1'b1, 5'd5,  5'd6,  5'd7,  1'b0, OPEN};
        vecs[5] = '{1'b0, 5'd9,  5'd9,  5'd9,  1'b0, OPEN};
        vecs[6] = '{1'b1, 5'd31, 5'd31, 5'd31, 1'b1, HAZ};
        vecs[7] = '{1'b1, 5'd4,  5'd1,  5'd2,  1'b1, BRANCH};

        clear_inputs();
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        nxt();
        i_rst = 1'b0;
        #1;
        check("reset_state", 32'(obs()), 32'(expect_of(PAUSE, FROZEN)));
        check("reset_cycles", 32'(o_cycles), 32'd0);

        repeat (10) nxt();
        #1;
        check("idle_state", 32'(obs()), 32'(expect_of(PAUSE, FROZEN)));
        check("idle_cycles", 32'(o_cycles), 32'd0);

        // Three single-cycle steps.
        for (int k = 0; k < 3; k++) begin
            nxt();
            i_cmd_step = 1'b1;
            nxt();
            i_cmd_step = 1'b0;
            #1;
            check($sformatf("step%0d_open", k), 32'(obs()), 32'(expect_of(STEP, OPEN)));
            check($sformatf("step%0d_cycles", k), 32'(o_cycles), 32'(k));
            nxt();
            #1;
            check($sformatf("step%0d_back", k), 32'(obs()), 32'(expect_of(PAUSE, FROZEN)));
            repeat (3) nxt();
        end
        #1;
        check("steps_cycles", 32'(o_cycles), 32'd3);

        // Enter RUN, then the hazard/branch table, one vector per cycle.
        nxt();
        i_cmd_run = 1'b1;
        nxt();
        i_cmd_run = 1'b0;
        #1;
        check("run_enter", 32'(obs()), 32'(expect_of(RUN, OPEN)));
        for (int i = 0; i < 8; i++) begin
            nxt();
            EX_memread     = vecs[i].memread;
            EX_rt          = vecs[i].ex_rt;
            ID_rs          = vecs[i].id_rs;
            ID_rt          = vecs[i].id_rt;
            i_branch_taken = vecs[i].branch;
            #1;
            check($sformatf("vec%0d", i), 32'(obs()), 32'(expect_of(RUN, vecs[i].exp_ctrl)));
        end
        nxt();
        clear_inputs();
        #1;
        check("run_cycles", 32'(o_cycles), 32'd12);

        // HALT blocked by a load-use hazard stays in RUN.
        EX_memread = 1'b1;
        EX_rt      = 5'd8;
        ID_rs      = 5'd8;
        i_halt_id  = 1'b1;
        #1;
        check("halt_haz", 32'(obs()), 32'(expect_of(RUN, HAZ)));
        nxt();
        EX_memread = 1'b0;
        #1;
        check("halt_free", 32'(obs()), 32'(expect_of(RUN, OPEN)));
        check("halt_cycles", 32'(o_cycles), 32'd13);

        // Four DRAIN cycles, cmd_run in the second one is ignored.
        for (int d = 0; d < 4; d++) begin
            nxt();
            clear_inputs();
            i_cmd_run = (d == 1);
            #1;
            check($sformatf("drain%0d", d), 32'(obs()), 32'(expect_of(DRAIN, DRAINO)));
        end
        nxt();
        clear_inputs();
        #1;
        check("halted", 32'(obs()), 32'(expect_of(HALTED, FROZEN)));
        check("cycles_saturated", 32'(o_cycles), 32'd15);

        i_cmd_run  = 1'b1;
        i_cmd_step = 1'b1;
        repeat (3) nxt();
        clear_inputs();
        #1;
        check("halted_sticky", 32'(obs()), 32'(expect_of(HALTED, FROZEN)));

        // Reset out of HALTED, then command priority in PAUSE.
        i_rst = 1'b1;
        nxt();
        i_rst = 1'b0;
        #1;
        check("rst_halted", 32'(obs()), 32'(expect_of(PAUSE, FROZEN)));
        check("rst_halted_cycles", 32'(o_cycles), 32'd0);

        i_cmd_halt = 1'b1;
        i_cmd_step = 1'b1;
        nxt();
        clear_inputs();
        #1;
        check("halt_over_step", 32'(obs()), 32'(expect_of(PAUSE, FROZEN)));

        i_cmd_step = 1'b1;
        i_cmd_run  = 1'b1;
        nxt();
        clear_inputs();
        #1;
        check("step_over_run", 32'(obs()), 32'(expect_of(STEP, OPEN)));
        nxt();
        #1;
        check("step_over_run_back", 32'(obs()), 32'(expect_of(PAUSE, FROZEN)));

        i_cmd_run = 1'b1;
        nxt();
        clear_inputs();
        i_cmd_halt = 1'b1;
        #1;
        check("run_again", 32'(obs()), 32'(expect_of(RUN, OPEN)));
        nxt();
        clear_inputs();
        #1;
        check("run_paused", 32'(obs()), 32'(expect_of(PAUSE, FROZEN)));

        // Reset in the second DRAIN cycle.
        i_cmd_run = 1'b1;
        nxt();
        clear_inputs();
        i_halt_id = 1'b1;
        nxt();
        clear_inputs();
        #1;
        check("drain2_first", 32'(obs()), 32'(expect_of(DRAIN, DRAINO)));
        nxt();
        i_rst = 1'b1;
        #1;
        check("drain2_second", 32'(obs()), 32'(expect_of(DRAIN, DRAINO)));
        nxt();
        i_rst = 1'b0;
        #1;
        check("rst_drain", 32'(obs()), 32'(expect_of(PAUSE, FROZEN)));
        check("rst_drain_cycles", 32'(o_cycles), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
